// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB stage: load-size codes, the occupancy
// encoding of the two-entry skid buffer and the payload held in each entry.
package mem_wb_pkg;

    // Load access sizes as carried by tamano_carga_entrada
    localparam logic [1:0] TAM_BYTE     = 2'b00;
    localparam logic [1:0] TAM_MEDIA    = 2'b01;
    localparam logic [1:0] TAM_PALABRA  = 2'b10;
    localparam logic [1:0] TAM_COMPLETO = 2'b11;

    // Payload fields are sized for the widest legal configuration; narrower
    // builds keep the unused upper bits at zero
    localparam int ANCHO_DATOS_MAX = 64;
    localparam int ANCHO_REG_MAX   = 8;

    // Occupancy of the stage: empty, main entry only, main plus skid entry
    typedef enum logic [1:0] {
        VACIO = 2'd0,
        UNO   = 2'd1,
        LLENO = 2'd2
    } estado_e;

    // One buffered writeback: final value, destination and write enable
    // (the enable already folds in the rd != 0 test)
    typedef struct packed {
        logic [ANCHO_DATOS_MAX-1:0] dato;
        logic [ANCHO_REG_MAX-1:0]   rd;
        logic                       escribe;
    } carga_util_t;

endpackage

// File: rtl/alineador_carga.sv
// Load-lane extractor: picks the byte/half/word lane addressed by the low
// address bits (aligned down to the access size) and sign- or zero-extends
// it to the full datapath width.
module alineador_carga
    import mem_wb_pkg::*;
#(
    parameter int ANCHO_DATOS = 32,
    localparam int ANCHO_DESP = $clog2(ANCHO_DATOS / 8)
) (
    input  logic [ANCHO_DATOS-1:0] dato_i,
    input  logic [ANCHO_DESP-1:0]  desplazamiento_i,
    input  logic [1:0]             tamano_i,
    input  logic                   sin_signo_i,
    output logic [ANCHO_DATOS-1:0] extendido_o
);

    localparam logic [ANCHO_DATOS-1:0] UNOS = '1;

    logic [ANCHO_DESP-1:0]  desp;
    logic [ANCHO_DATOS-1:0] mascara;
    logic [ANCHO_DATOS-1:0] desplazado;
    logic                   signo;

    // Align the offset, shift the lane down to bit 0, then mask and extend;
    // the full-width size uses offset 0 and an all-ones mask, so on a 32-bit
    // datapath it naturally degenerates to the word case
    always_comb begin
        desp    = desplazamiento_i;
        mascara = UNOS;
        signo   = 1'b0;
        case (tamano_i)
            TAM_BYTE: begin
                mascara = UNOS >> (ANCHO_DATOS - 8);
            end
            TAM_MEDIA: begin
                desp[0] = 1'b0;
                mascara = UNOS >> (ANCHO_DATOS - 16);
            end
            TAM_PALABRA: begin
                desp[1:0] = 2'b00;
                mascara   = UNOS >> (ANCHO_DATOS - 32);
            end
            default: begin
                desp    = '0;
                mascara = UNOS;
            end
        endcase
        desplazado = dato_i >> {desp, 3'b000};
        case (tamano_i)
            TAM_BYTE:    signo = desplazado[7];
            TAM_MEDIA:   signo = desplazado[15];
            TAM_PALABRA: signo = desplazado[31];
            default:     signo = 1'b0;
        endcase
        extendido_o = (desplazado & mascara) |
                      ((!sin_signo_i && signo) ? ~mascara : '0);
    end

endmodule

// File: rtl/etapa_mem_wb_param.sv
// MEM/WB pipeline stage with a two-entry skid buffer and registered upstream
// ready. The writeback value (load extraction + source mux) is computed at
// accept time and stored, so the outputs come straight from a register.
// Optional stall/bubble counters are enabled with MEM_WB_CONTADORES_EN.
module etapa_mem_wb_param
    import mem_wb_pkg::*;
#(
    parameter int ANCHO_DATOS = 32,
    parameter int ANCHO_REG   = 5
) (
    input  logic                   clk,
    input  logic                   reinicio_n,
    input  logic                   valido_entrada,
    output logic                   listo_entrada,
    input  logic                   vaciado,
    input  logic [ANCHO_DATOS-1:0] resultado_alu_entrada,
    input  logic [ANCHO_DATOS-1:0] dato_mem_entrada,
    input  logic [ANCHO_REG-1:0]   registro_destino_entrada,
    input  logic                   escribe_reg_entrada,
    input  logic                   mem_a_reg_entrada,
    input  logic [1:0]             tamano_carga_entrada,
    input  logic                   carga_sin_signo_entrada,
    output logic                   valido_salida,
    input  logic                   listo_salida,
    output logic [ANCHO_DATOS-1:0] dato_escritura_salida,
    output logic [ANCHO_REG-1:0]   registro_destino_salida,
    output logic                   escribe_reg_salida
`ifdef MEM_WB_CONTADORES_EN
    ,
    output logic [31:0]            ciclos_bloqueo,
    output logic [31:0]            ciclos_burbuja
`else
`endif
);

    localparam int BYTES_DATO = ANCHO_DATOS / 8;
    localparam int ANCHO_DESP = $clog2(BYTES_DATO);

    estado_e     estado_q, estado_d;
    carga_util_t principal_q, principal_d;
    carga_util_t skid_q, skid_d;
    carga_util_t nuevo;
    logic        listo_q;
    logic [ANCHO_DATOS-1:0] dato_carga;
    logic        acepta;
    logic        envia;

    alineador_carga #(
        .ANCHO_DATOS(ANCHO_DATOS)
    ) u_alineador (
        .dato_i          (dato_mem_entrada),
        .desplazamiento_i(resultado_alu_entrada[ANCHO_DESP-1:0]),
        .tamano_i        (tamano_carga_entrada),
        .sin_signo_i     (carga_sin_signo_entrada),
        .extendido_o     (dato_carga)
    );

    assign acepta = valido_entrada & listo_q;
    assign envia  = valido_salida & listo_salida;

    // Build the entry that would be stored if the incoming payload is accepted
    always_comb begin
        nuevo                          = '0;
        nuevo.dato[ANCHO_DATOS-1:0]    = mem_a_reg_entrada ? dato_carga : resultado_alu_entrada;
        nuevo.rd[ANCHO_REG-1:0]        = registro_destino_entrada;
        nuevo.escribe                  = escribe_reg_entrada & (registro_destino_entrada != '0);
    end

    // Occupancy next state; flush overrides any accept or send
    always_comb begin
        estado_d = estado_q;
        if (vaciado) begin
            estado_d = VACIO;
        end else begin
            case (estado_q)
                VACIO: if (acepta) estado_d = UNO;
                UNO: begin
                    if (acepta && !envia)      estado_d = LLENO;
                    else if (!acepta && envia) estado_d = VACIO;
                end
                LLENO: if (envia) estado_d = UNO;
                default: estado_d = VACIO;
            endcase
        end
    end

    // Entry updates; entries that are not written keep their old contents so
    // the outputs hold their last value while the stage is empty
    always_comb begin
        principal_d = principal_q;
        skid_d      = skid_q;
        if (!vaciado) begin
            case (estado_q)
                VACIO: if (acepta) principal_d = nuevo;
                UNO: begin
                    if (acepta && envia) principal_d = nuevo;
                    else if (acepta)     skid_d      = nuevo;
                end
                LLENO: if (envia) principal_d = skid_q;
                default: ;
            endcase
        end
    end

    // State, entries and registered upstream ready
    always_ff @(posedge clk or negedge reinicio_n) begin
        if (!reinicio_n) begin
            estado_q    <= VACIO;
            listo_q     <= 1'b0;
            principal_q <= '0;
            skid_q      <= '0;
        end else begin
            estado_q    <= estado_d;
            listo_q     <= (estado_d != LLENO);
            principal_q <= principal_d;
            skid_q      <= skid_d;
        end
    end

    // Outputs come directly from the main entry
    always_comb begin
        valido_salida           = (estado_q != VACIO);
        listo_entrada           = listo_q;
        dato_escritura_salida   = principal_q.dato[ANCHO_DATOS-1:0];
        registro_destino_salida = principal_q.rd[ANCHO_REG-1:0];
        escribe_reg_salida      = valido_salida & principal_q.escribe;
    end

`ifdef MEM_WB_CONTADORES_EN
    logic [31:0] bloqueo_q;
    logic [31:0] burbuja_q;

    // Saturating stall and bubble counters, cleared by reset and flush
    always_ff @(posedge clk or negedge reinicio_n) begin
        if (!reinicio_n) begin
            bloqueo_q <= '0;
            burbuja_q <= '0;
        end else if (vaciado) begin
            bloqueo_q <= '0;
            burbuja_q <= '0;
        end else begin
            if (valido_salida && !listo_salida && (bloqueo_q != 32'hFFFF_FFFF))
                bloqueo_q <= bloqueo_q + 32'd1;
            if (!valido_salida && (burbuja_q != 32'hFFFF_FFFF))
                burbuja_q <= burbuja_q + 32'd1;
        end
    end

    assign ciclos_bloqueo = bloqueo_q;
    assign ciclos_burbuja = burbuja_q;
`else
`endif

endmodule

// File: tb/tb_etapa_mem_wb_param.sv
// Self-checking bench for etapa_mem_wb_param (32-bit datapath). Expected
// writebacks are queued when the stage accepts and compared when it sends.
// Build with MEM_WB_CONTADORES_EN to also exercise the stall counter.
module tb_etapa_mem_wb_param;

    logic        clk = 1'b0;
    logic        reinicio_n;
    logic        valido_entrada;
    logic        listo_entrada;
    logic        vaciado;
    logic [31:0] resultado_alu_entrada;
    logic [31:0] dato_mem_entrada;
    logic [4:0]  registro_destino_entrada;
    logic        escribe_reg_entrada;
    logic        mem_a_reg_entrada;
    logic [1:0]  tamano_carga_entrada;
    logic        carga_sin_signo_entrada;
    logic        valido_salida;
    logic        listo_salida;
    logic [31:0] dato_escritura_salida;
    logic [4:0]  registro_destino_salida;
    logic        escribe_reg_salida;
`ifdef MEM_WB_CONTADORES_EN
    logic [31:0] ciclos_bloqueo;
    logic [31:0] ciclos_burbuja;
`endif

    int          assertCount = 0;
    int          failCount   = 0;
    logic [37:0] expQueue[$];
    logic [37:0] espActual;

    etapa_mem_wb_param #(.ANCHO_DATOS(32), .ANCHO_REG(5)) dut (
        .clk                     (clk),
        .reinicio_n              (reinicio_n),
        .valido_entrada          (valido_entrada),
        .listo_entrada           (listo_entrada),
        .vaciado                 (vaciado),
        .resultado_alu_entrada   (resultado_alu_entrada),
        .dato_mem_entrada        (dato_mem_entrada),
        .registro_destino_entrada(registro_destino_entrada),
        .escribe_reg_entrada     (escribe_reg_entrada),
        .mem_a_reg_entrada       (mem_a_reg_entrada),
        .tamano_carga_entrada    (tamano_carga_entrada),
        .carga_sin_signo_entrada (carga_sin_signo_entrada),
        .valido_salida           (valido_salida),
        .listo_salida            (listo_salida),
        .dato_escritura_salida   (dato_escritura_salida),
        .registro_destino_salida (registro_destino_salida),
        .escribe_reg_salida      (escribe_reg_salida)
`ifdef MEM_WB_CONTADORES_EN
        ,
        .ciclos_bloqueo          (ciclos_bloqueo),
        .ciclos_burbuja          (ciclos_burbuja)
`endif
    );

    always #5 clk = ~clk;

    // Safety net so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference writeback value for a 32-bit datapath: {dato, rd, escribe}
    function automatic logic [37:0] modelo(input logic [31:0] alu, input logic [31:0] mem,
                                           input logic [4:0] rd, input logic wr, input logic m2r,
                                           input logic [1:0] tam, input logic sinSigno);
        logic [31:0] v;
        logic [1:0]  o;
        o = alu[1:0];
        case (tam)
            2'b00: begin
                v = {24'h0, mem[o*8 +: 8]};
                if (!sinSigno && v[7]) v[31:8] = '1;
            end
            2'b01: begin
                o[0] = 1'b0;
                v = {16'h0, mem[o*8 +: 16]};
                if (!sinSigno && v[15]) v[31:16] = '1;
            end
            default: v = mem;
        endcase
        if (!m2r) v = alu;
        return {v, rd, (wr && (rd != 5'd0))};
    endfunction

    task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                                 input logic [4:0] rd, input logic wr, input logic m2r,
                                 input logic [1:0] tam, input logic sinSigno);
        valido_entrada           = v;
        resultado_alu_entrada    = alu;
        dato_mem_entrada         = mem;
        registro_destino_entrada = rd;
        escribe_reg_entrada      = wr;
        mem_a_reg_entrada        = m2r;
        tamano_carga_entrada     = tam;
        carga_sin_signo_entrada  = sinSigno;
        espActual                = modelo(alu, mem, rd, wr, m2r, tam, sinSigno);
    endtask

    // One clock: score the handshakes seen at this negedge, advance to the
    // next negedge, and verify the payload held steady across a stall
    task automatic paso();
        logic [37:0] esp;
        logic [37:0] guardado;
        logic        enBloqueo;
        enBloqueo = reinicio_n && !vaciado && valido_salida && !listo_salida;
        guardado  = {dato_escritura_salida, registro_destino_salida, escribe_reg_salida};
        if (reinicio_n) begin
            if (vaciado) begin
                expQueue.delete();
            end else begin
                if (valido_salida && listo_salida) begin
                    checkOutput("salida_esperada", 64'(expQueue.size() != 0), 64'd1);
                    if (expQueue.size() != 0) begin
                        esp = expQueue.pop_front();
                        checkOutput("dato", 64'(dato_escritura_salida), 64'(esp[37:6]));
                        checkOutput("rd", 64'(registro_destino_salida), 64'(esp[5:1]));
                        checkOutput("escribe", 64'(escribe_reg_salida), 64'(esp[0]));
                    end
                end
                if (valido_entrada && listo_entrada) expQueue.push_back(espActual);
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (enBloqueo) begin
            checkOutput("bloqueo_valido", 64'(valido_salida), 64'd1);
            checkOutput("bloqueo_estable",
                        64'({dato_escritura_salida, registro_destino_salida, escribe_reg_salida}),
                        64'(guardado));
        end
    endtask

    task automatic drenar(input string tag);
        valido_entrada = 1'b0;
        vaciado        = 1'b0;
        listo_salida   = 1'b1;
        for (int i = 0; i < 10 && expQueue.size() != 0; i++) paso();
        checkOutput(tag, 64'(expQueue.size()), 64'd0);
    endtask

    initial begin
        logic [1:0]  tamTabla [6];
        logic [1:0]  offTabla [6];
        logic        sinTabla [6];
        logic [31:0] espTabla [6];
        int          dummy;

        tamTabla = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
        offTabla = '{2'd3, 2'd2, 2'd2, 2'd3, 2'd1, 2'd2};
        sinTabla = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        espTabla = '{32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF, 32'hFFFF80FF,
                     32'h80FF7F01, 32'h80FF7F01};

        reinicio_n   = 1'b0;
        vaciado      = 1'b0;
        listo_salida = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_valido", 64'(valido_salida), 64'd0);
        checkOutput("rst_listo", 64'(listo_entrada), 64'd0);
        checkOutput("rst_dato", 64'(dato_escritura_salida), 64'd0);
        checkOutput("rst_rd", 64'(registro_destino_salida), 64'd0);
        checkOutput("rst_escribe", 64'(escribe_reg_salida), 64'd0);
        reinicio_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_listo_tras", 64'(listo_entrada), 64'd1);

        // Streaming: 8 back-to-back ALU results
        $display("[TB] streaming");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h1111_0000 + 32'(i * 37), 32'hDEAD_BEEF, 5'(i + 1),
                          1'b1, 1'b0, 2'b10, 1'b0);
            paso();
            checkOutput("flujo_valido", 64'(valido_salida), 64'd1);
            checkOutput("flujo_listo", 64'(listo_entrada), 64'd1);
        end
        valido_entrada = 1'b0;
        paso();
        checkOutput("flujo_fin", 64'(valido_salida), 64'd0);
        checkOutput("flujo_cola", 64'(expQueue.size()), 64'd0);

        // Stall for 3 cycles mid-stream
        $display("[TB] stall");
        applyStimulus(1'b1, 32'hA, 32'h0, 5'd10, 1'b1, 1'b0, 2'b10, 1'b0);
        paso();
        listo_salida = 1'b0;
        applyStimulus(1'b1, 32'hB, 32'h0, 5'd11, 1'b1, 1'b0, 2'b10, 1'b0);
        paso();
        checkOutput("skid_listo_cae", 64'(listo_entrada), 64'd0);
        applyStimulus(1'b1, 32'hC, 32'h0, 5'd12, 1'b0, 1'b0, 2'b10, 1'b0);
        paso();
        checkOutput("skid_listo_bajo", 64'(listo_entrada), 64'd0);
        paso();
        listo_salida = 1'b1;
        paso();
        paso();
        valido_entrada = 1'b0;
        drenar("bloqueo_cola");

        // Load lanes, memory word 0x80FF7F01
        $display("[TB] load lanes");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'h2000 | 32'(offTabla[i]), 32'h80FF7F01, 5'd3, 1'b1, 1'b1,
                          tamTabla[i], sinTabla[i]);
            espActual = {espTabla[i], 5'd3, 1'b1};
            paso();
        end
        drenar("carril_cola");

        // Flush with the stage full and a valid input present
        $display("[TB] flush");
        listo_salida = 1'b0;
        applyStimulus(1'b1, 32'h51, 32'h0, 5'd5, 1'b1, 1'b0, 2'b10, 1'b0);
        paso();
        applyStimulus(1'b1, 32'h52, 32'h0, 5'd6, 1'b1, 1'b0, 2'b10, 1'b0);
        paso();
        applyStimulus(1'b1, 32'h53, 32'h0, 5'd7, 1'b1, 1'b0, 2'b10, 1'b0);
        vaciado = 1'b1;
        paso();
        vaciado = 1'b0;
        valido_entrada = 1'b0;
        checkOutput("vaciado_valido", 64'(valido_salida), 64'd0);
        checkOutput("vaciado_listo", 64'(listo_entrada), 64'd1);
        listo_salida = 1'b1;
        applyStimulus(1'b1, 32'h54, 32'h0, 5'd8, 1'b1, 1'b0, 2'b10, 1'b0);
        paso();
        // Flush from a single entry while a new payload would be accepted
        applyStimulus(1'b1, 32'h55, 32'h0, 5'd9, 1'b1, 1'b0, 2'b10, 1'b0);
        vaciado = 1'b1;
        paso();
        vaciado = 1'b0;
        valido_entrada = 1'b0;
        checkOutput("vaciado_uno", 64'(valido_salida), 64'd0);
        drenar("vaciado_cola");

        // Register 0 never writes
        applyStimulus(1'b1, 32'h77, 32'h0, 5'd0, 1'b1, 1'b0, 2'b10, 1'b0);
        paso();
        checkOutput("rd0_valido", 64'(valido_salida), 64'd1);
        checkOutput("rd0_escribe", 64'(escribe_reg_salida), 64'd0);
        drenar("rd0_cola");

        // Asynchronous reset in the middle of traffic
        $display("[TB] async reset");
        listo_salida = 1'b0;
        applyStimulus(1'b1, 32'h1234_5678, 32'h0, 5'd21, 1'b1, 1'b0, 2'b10, 1'b0);
        paso();
        applyStimulus(1'b1, 32'h9ABC_DEF0, 32'h0, 5'd22, 1'b1, 1'b0, 2'b10, 1'b0);
        paso();
        valido_entrada = 1'b0;
        #2;
        reinicio_n = 1'b0;
        #1;
        checkOutput("arst_valido", 64'(valido_salida), 64'd0);
        checkOutput("arst_listo", 64'(listo_entrada), 64'd0);
        checkOutput("arst_dato", 64'(dato_escritura_salida), 64'd0);
        checkOutput("arst_rd", 64'(registro_destino_salida), 64'd0);
        checkOutput("arst_escribe", 64'(escribe_reg_salida), 64'd0);
        expQueue.delete();
        @(negedge clk);
        reinicio_n = 1'b1;
        listo_salida = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("arst_listo_tras", 64'(listo_entrada), 64'd1);

`ifdef MEM_WB_CONTADORES_EN
        // Five stalled cycles after a flush clears the counters
        vaciado = 1'b1;
        paso();
        vaciado = 1'b0;
        applyStimulus(1'b1, 32'h99, 32'h0, 5'd4, 1'b1, 1'b0, 2'b10, 1'b0);
        paso();
        valido_entrada = 1'b0;
        listo_salida = 1'b0;
        for (int i = 0; i < 5; i++) paso();
        checkOutput("ciclos_bloqueo", 64'(ciclos_bloqueo), 64'd5);
        checkOutput("ciclos_burbuja", 64'(ciclos_burbuja), 64'd1);
        drenar("contador_cola");
`endif

        // Random traffic with random back-pressure and occasional flushes
        $display("[TB] random");
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom(), $urandom(),
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
            listo_salida = ($urandom_range(0, 3) != 0);
            vaciado      = ($urandom_range(0, 19) == 0);
            paso();
        end
        drenar("aleatorio_cola");
        dummy = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
